sound_mem_arbiter: RTL and testbench



---
 rtl/sound_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 tb/tb_sound_mem_arbiter.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_mem_arbiter.sv
// sound_mem_arbiter
//
// Serves the two sound memory clients (GLU and DOC) on the responder side of
// the sound memory port protocol. It holds one pending request per client,
// picks a winner, and issues requests one at a time to a single upstream
// SDRAM controller port using the same protocol. Read data and ready go back
// only to the client that made the request.
//
// Parameters:
//   DOC_PRIORITY   : 1 = DOC wins when both are pending, 0 = round-robin
//                    (GLU first after reset)
//   TIMEOUT_CYCLES : watchdog limit in clk_i cycles (optional feature only)
//
// Optional feature macro: SOUND_MEM_ARB_TIMEOUT_EN
//   Defined     : a stuck upstream transaction is completed after
//                 TIMEOUT_CYCLES. Reads return 32'hFFFF_FFFF and the sticky
//                 timeout_o flag is set.
//   Not defined : the arbiter waits on the upstream indefinitely and
//                 timeout_o stays 0.
//
// Ports:
//   clk_i, reset_i               : clock, synchronous active-high reset
//   glu_* / doc_* inputs         : client rd/wr strobes, addr, data, byte_en
//   glu_ready_o / doc_ready_o    : 1 = client idle, 0 = request in flight
//   glu_q_o / doc_q_o            : client read data, held until the next read
//   mem_rd_o / mem_wr_o          : upstream one-cycle strobes
//   mem_addr_o/data_o/byte_en_o  : upstream request, held until completion
//   mem_ready_i / mem_q_i        : upstream ready and read data
//   timeout_o                    : sticky watchdog flag

module sound_mem_arbiter #(
    parameter int DOC_PRIORITY   = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        glu_rd_i,
    input  logic        glu_wr_i,
    input  logic [23:0] glu_addr_i,
    input  logic [31:0] glu_data_i,
    input  logic [3:0]  glu_byte_en_i,
    output logic        glu_ready_o,
    output logic [31:0] glu_q_o,
    input  logic        doc_rd_i,
    input  logic        doc_wr_i,
    input  logic [23:0] doc_addr_i,
    input  logic [31:0] doc_data_i,
    input  logic [3:0]  doc_byte_en_i,
    output logic        doc_ready_o,
    output logic [31:0] doc_q_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic [23:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_byte_en_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_q_i,
    output logic        timeout_o
);

    localparam int DATA_W = 32;
    localparam int ADDR_W = 24;
    localparam int BE_W   = 4;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Pending slots, one per client
    logic              glu_pend;
    logic              doc_pend;
    logic              glu_op_wr;
    logic              doc_op_wr;
    logic [ADDR_W-1:0] glu_addr_q;
    logic [ADDR_W-1:0] doc_addr_q;
    logic [DATA_W-1:0] glu_data_q;
    logic [DATA_W-1:0] doc_data_q;
    logic [BE_W-1:0]   glu_be_q;
    logic [BE_W-1:0]   doc_be_q;

    // Transaction in flight
    logic              rr_doc;     // 1: DOC is next in round-robin order
    logic              cur_doc;    // 1: current upstream request belongs to DOC
    logic              cur_wr;     // 1: current upstream request is a write

    logic              glu_cap;
    logic              doc_cap;
    logic              win_doc;
    logic              grant;
    logic              mem_done;
    logic              timeout_hit;
    logic              done;
    logic [DATA_W-1:0] done_q;

    assign glu_ready_o = !glu_pend;
    assign doc_ready_o = !doc_pend;

    // Strobes are only looked at while the client is idle.
    assign glu_cap = !glu_pend && (glu_rd_i || glu_wr_i);
    assign doc_cap = !doc_pend && (doc_rd_i || doc_wr_i);

    // DOC wins when it is alone, when it has fixed priority, or when it
    // holds the round-robin turn.
    assign win_doc = doc_pend && (!glu_pend || (DOC_PRIORITY != 0) || rr_doc);
    assign grant   = (state == IDLE) && (glu_pend || doc_pend) && mem_ready_i;

    assign mem_done = (state == WAIT_DONE) && mem_ready_i;
    assign done     = mem_done || timeout_hit;
    // A real completion wins over a watchdog hit in the same cycle.
    assign done_q   = mem_done ? mem_q_i : {DATA_W{1'b1}};

`ifdef SOUND_MEM_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            waiting;

    assign waiting     = (state == WAIT_ACK) || (state == WAIT_DONE);
    assign timeout_hit = waiting && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            to_cnt <= '0;
        end else if (state == ISSUE) begin
            to_cnt <= '0;
        end else if (waiting) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (timeout_hit) begin
                    state_nxt = IDLE;
                end else if (!mem_ready_i) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: the upstream strobe is high for the single ISSUE cycle.
    always_comb begin
        mem_rd_o = 1'b0;
        mem_wr_o = 1'b0;
        if (state == ISSUE) begin
            mem_rd_o = !cur_wr;
            mem_wr_o = cur_wr;
        end
    end

    // Slot payload; only meaningful while the matching pending bit is set.
    // A simultaneous rd and wr is recorded as a write.
    always_ff @(posedge clk_i) begin
        if (glu_cap) begin
            glu_op_wr  <= glu_wr_i;
            glu_addr_q <= glu_addr_i;
            glu_data_q <= glu_data_i;
            glu_be_q   <= glu_byte_en_i;
        end
        if (doc_cap) begin
            doc_op_wr  <= doc_wr_i;
            doc_addr_q <= doc_addr_i;
            doc_data_q <= doc_data_i;
            doc_be_q   <= doc_byte_en_i;
        end
    end

    // Control, upstream request registers and client read data
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            glu_pend      <= 1'b0;
            doc_pend      <= 1'b0;
            rr_doc        <= 1'b0;
            cur_doc       <= 1'b0;
            cur_wr        <= 1'b0;
            timeout_o     <= 1'b0;
            glu_q_o       <= '0;
            doc_q_o       <= '0;
            mem_addr_o    <= '0;
            mem_data_o    <= '0;
            mem_byte_en_o <= '0;
        end else begin
            // Completion and capture never coincide for one client: a
            // completing client is pending, a capturing one is not.
            if (done && !cur_doc) begin
                glu_pend <= 1'b0;
            end else if (glu_cap) begin
                glu_pend <= 1'b1;
            end
            if (done && cur_doc) begin
                doc_pend <= 1'b0;
            end else if (doc_cap) begin
                doc_pend <= 1'b1;
            end

            // The request registers stay untouched until the next grant,
            // which keeps them stable for the whole upstream transaction.
            if (grant) begin
                cur_doc       <= win_doc;
                rr_doc        <= !win_doc;
                cur_wr        <= win_doc ? doc_op_wr  : glu_op_wr;
                mem_addr_o    <= win_doc ? doc_addr_q : glu_addr_q;
                mem_data_o    <= win_doc ? doc_data_q : glu_data_q;
                mem_byte_en_o <= win_doc ? doc_be_q   : glu_be_q;
            end

            if (done && !cur_wr) begin
                if (cur_doc) begin
                    doc_q_o <= done_q;
                end else begin
                    glu_q_o <= done_q;
                end
            end

            if (timeout_hit && !mem_done) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sound_mem_arbiter.sv
// Testbench for sound_mem_arbiter. Two instances share the client stimulus:
// u_pri uses DOC_PRIORITY = 1, u_rr uses DOC_PRIORITY = 0. Each instance has
// its own behavioural upstream responder that logs every request it sees.

module tb_sound_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        glu_rd = 1'b0, glu_wr = 1'b0;
    logic [23:0] glu_addr = '0;
    logic [31:0] glu_data = '0;
    logic [3:0]  glu_be = '0;
    logic        doc_rd = 1'b0, doc_wr = 1'b0;
    logic [23:0] doc_addr = '0;
    logic [31:0] doc_data = '0;
    logic [3:0]  doc_be = '0;
    logic        resp_hang = 1'b0;

    // u_pri side
    logic        a_glu_ready, a_doc_ready, a_mem_rd, a_mem_wr, a_timeout;
    logic [31:0] a_glu_q, a_doc_q, a_mem_data;
    logic [23:0] a_mem_addr;
    logic [3:0]  a_mem_be;
    logic        a_mem_ready = 1'b1;
    logic [31:0] a_mem_q = '0;
    logic        a_busy = 1'b0, a_prev_stb = 1'b0;
    int          a_cnt = 0, a_log_n = 0, a_dbl = 0;
    logic [23:0] a_log_addr [0:63];
    logic [31:0] a_log_data [0:63];
    logic [3:0]  a_log_be   [0:63];
    logic        a_log_wr   [0:63];

    // u_rr side
    logic        b_glu_ready, b_doc_ready, b_mem_rd, b_mem_wr, b_timeout;
    logic [31:0] b_glu_q, b_doc_q, b_mem_data;
    logic [23:0] b_mem_addr;
    logic [3:0]  b_mem_be;
    logic        b_mem_ready = 1'b1;
    logic [31:0] b_mem_q = '0;
    logic        b_busy = 1'b0, b_prev_stb = 1'b0;
    int          b_cnt = 0, b_log_n = 0, b_dbl = 0;
    logic [23:0] b_log_addr [0:63];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sound_mem_arbiter #(.DOC_PRIORITY(1), .TIMEOUT_CYCLES(16)) u_pri (
        .clk_i(clk), .reset_i(reset),
        .glu_rd_i(glu_rd), .glu_wr_i(glu_wr), .glu_addr_i(glu_addr),
        .glu_data_i(glu_data), .glu_byte_en_i(glu_be),
        .glu_ready_o(a_glu_ready), .glu_q_o(a_glu_q),
        .doc_rd_i(doc_rd), .doc_wr_i(doc_wr), .doc_addr_i(doc_addr),
        .doc_data_i(doc_data), .doc_byte_en_i(doc_be),
        .doc_ready_o(a_doc_ready), .doc_q_o(a_doc_q),
        .mem_rd_o(a_mem_rd), .mem_wr_o(a_mem_wr), .mem_addr_o(a_mem_addr),
        .mem_data_o(a_mem_data), .mem_byte_en_o(a_mem_be),
        .mem_ready_i(a_mem_ready), .mem_q_i(a_mem_q), .timeout_o(a_timeout)
    );

    sound_mem_arbiter #(.DOC_PRIORITY(0), .TIMEOUT_CYCLES(16)) u_rr (
        .clk_i(clk), .reset_i(reset),
        .glu_rd_i(glu_rd), .glu_wr_i(glu_wr), .glu_addr_i(glu_addr),
        .glu_data_i(glu_data), .glu_byte_en_i(glu_be),
        .glu_ready_o(b_glu_ready), .glu_q_o(b_glu_q),
        .doc_rd_i(doc_rd), .doc_wr_i(doc_wr), .doc_addr_i(doc_addr),
        .doc_data_i(doc_data), .doc_byte_en_i(doc_be),
        .doc_ready_o(b_doc_ready), .doc_q_o(b_doc_q),
        .mem_rd_o(b_mem_rd), .mem_wr_o(b_mem_wr), .mem_addr_o(b_mem_addr),
        .mem_data_o(b_mem_data), .mem_byte_en_o(b_mem_be),
        .mem_ready_i(b_mem_ready), .mem_q_i(b_mem_q), .timeout_o(b_timeout)
    );

    // Upstream read data: fixed pattern for the test-plan address, else tagged address.
    function automatic logic [31:0] resp_val(input logic [23:0] a);
        return (a == 24'h001234) ? 32'hA5A55A5A : {8'h5C, a};
    endfunction

    // Responder: ready drops the cycle after a strobe and rises 4 cycles later.
    // It ignores the arbiter reset so late completions can be observed.
    always @(posedge clk) begin
        a_prev_stb <= a_mem_rd | a_mem_wr;
        if ((a_mem_rd | a_mem_wr) && a_prev_stb) a_dbl <= a_dbl + 1;
        if (!a_busy && (a_mem_rd || a_mem_wr)) begin
            a_busy <= 1'b1;
            a_mem_ready <= 1'b0;
            a_cnt <= 0;
            if (a_log_n < 64) begin
                a_log_addr[a_log_n] <= a_mem_addr;
                a_log_data[a_log_n] <= a_mem_data;
                a_log_be[a_log_n]   <= a_mem_be;
                a_log_wr[a_log_n]   <= a_mem_wr;
            end
            a_log_n <= a_log_n + 1;
        end else if (a_busy && !resp_hang) begin
            a_cnt <= a_cnt + 1;
            if (a_cnt == 3) begin
                a_mem_ready <= 1'b1;
                a_busy <= 1'b0;
                a_mem_q <= resp_val(a_mem_addr);
            end
        end
    end

    always @(posedge clk) begin
        b_prev_stb <= b_mem_rd | b_mem_wr;
        if ((b_mem_rd | b_mem_wr) && b_prev_stb) b_dbl <= b_dbl + 1;
        if (!b_busy && (b_mem_rd || b_mem_wr)) begin
            b_busy <= 1'b1;
            b_mem_ready <= 1'b0;
            b_cnt <= 0;
            if (b_log_n < 64) b_log_addr[b_log_n] <= b_mem_addr;
            b_log_n <= b_log_n + 1;
        end else if (b_busy && !resp_hang) begin
            b_cnt <= b_cnt + 1;
            if (b_cnt == 3) begin
                b_mem_ready <= 1'b1;
                b_busy <= 1'b0;
                b_mem_q <= resp_val(b_mem_addr);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        glu_rd = 1'b0; glu_wr = 1'b0; doc_rd = 1'b0; doc_wr = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            if (a_glu_ready && a_doc_ready && b_glu_ready && b_doc_ready && !a_busy && !b_busy)
                ok = 1'b1;
            else
                tick();
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({a_glu_ready, a_doc_ready, a_mem_rd, a_mem_wr, a_timeout} !== 5'b11000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 11000", {a_glu_ready, a_doc_ready, a_mem_rd, a_mem_wr, a_timeout});
        end
        total++;
        if (a_glu_q !== 32'h0 || a_doc_q !== 32'h0) begin
            bad++;
            $display("FAIL reset_q: got glu=%h doc=%h want 0", a_glu_q, a_doc_q);
        end
        total++;
        if (a_mem_addr !== 24'h0 || a_mem_data !== 32'h0 || a_mem_be !== 4'h0) begin
            bad++;
            $display("FAIL reset_mem: got addr=%h data=%h be=%h want 0", a_mem_addr, a_mem_data, a_mem_be);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_glu_read();
        int rdy_cyc;
        bit ok;
        rdy_cyc = -1;
        glu_rd = 1'b1; glu_addr = 24'h001234;            // cycle 0
        tick();                                          // cycle 1
        clear_inputs();
        total++;
        if (a_glu_ready !== 1'b0 || a_mem_rd !== 1'b0) begin
            bad++;
            $display("FAIL rd_cycle1: got ready=%b mem_rd=%b want 0 0", a_glu_ready, a_mem_rd);
        end
        tick();                                          // cycle 2
        total++;
        if (a_mem_rd !== 1'b1 || a_mem_wr !== 1'b0 || a_mem_addr !== 24'h001234) begin
            bad++;
            $display("FAIL rd_issue: got rd=%b wr=%b addr=%h want 1 0 001234", a_mem_rd, a_mem_wr, a_mem_addr);
        end
        for (int c = 3; c <= 20 && rdy_cyc < 0; c++) begin
            tick();
            if (a_glu_ready === 1'b1) rdy_cyc = c;
        end
        total++;
        if (rdy_cyc != 8) begin
            bad++;
            $display("FAIL rd_latency: got ready cycle %0d want 8", rdy_cyc);
        end
        total++;
        if (a_glu_q !== 32'hA5A55A5A) begin
            bad++;
            $display("FAIL rd_data: got %h want a5a55a5a", a_glu_q);
        end
        total++;
        if (a_doc_ready !== 1'b1 || a_doc_q !== 32'h0) begin
            bad++;
            $display("FAIL rd_doc_untouched: got ready=%b q=%h want 1 0", a_doc_ready, a_doc_q);
        end
        wait_idle(50, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rd_idle: got busy want idle"); end
    endtask

    task automatic test_doc_priority();
        int n0;
        bit ok;
        n0 = a_log_n;
        glu_rd = 1'b1; glu_addr = 24'h000100;
        doc_rd = 1'b1; doc_addr = 24'h000200;
        tick();
        clear_inputs();
        wait_idle(100, ok);
        total++;
        if (!ok || a_log_n != n0 + 2) begin
            bad++;
            $display("FAIL prio_count: got %0d requests idle=%0d want 2", a_log_n - n0, ok);
        end
        total++;
        if (a_log_addr[n0] !== 24'h000200 || a_log_addr[n0+1] !== 24'h000100) begin
            bad++;
            $display("FAIL prio_order: got %h,%h want 000200,000100", a_log_addr[n0], a_log_addr[n0+1]);
        end
        total++;
        if (a_glu_q !== 32'h5C000100 || a_doc_q !== 32'h5C000200) begin
            bad++;
            $display("FAIL prio_data: got glu=%h doc=%h want 5c000100 5c000200", a_glu_q, a_doc_q);
        end
    endtask

    task automatic test_round_robin();
        int n0, g, d;
        bit ok;
        logic [23:0] exp;
        do_reset();
        n0 = b_log_n;
        g = 0;
        d = 0;
        for (int c = 0; c < 400 && (g < 4 || d < 4); c++) begin
            glu_rd = 1'b0;
            doc_rd = 1'b0;
            if (b_glu_ready && g < 4) begin
                glu_rd = 1'b1; glu_addr = 24'h000300 + 24'(g); g++;
            end
            if (b_doc_ready && d < 4) begin
                doc_rd = 1'b1; doc_addr = 24'h000400 + 24'(d); d++;
            end
            tick();
        end
        clear_inputs();
        wait_idle(200, ok);
        total++;
        if (!ok || b_log_n != n0 + 8) begin
            bad++;
            $display("FAIL rr_count: got %0d requests idle=%0d want 8", b_log_n - n0, ok);
        end
        for (int i = 0; i < 8; i++) begin
            exp = (((i % 2) == 0) ? 24'h000300 : 24'h000400) + 24'(i / 2);
            total++;
            if (b_log_addr[n0+i] !== exp) begin
                bad++;
                $display("FAIL rr_grant%0d: got %h want %h", i, b_log_addr[n0+i], exp);
            end
        end
    endtask

    task automatic test_doc_write();
        int n0;
        bit ok;
        do_reset();
        n0 = a_log_n;
        doc_wr = 1'b1; doc_addr = 24'h000ABC; doc_data = 32'h11223344; doc_be = 4'b0011;
        tick();
        clear_inputs();
        wait_idle(100, ok);
        total++;
        if (!ok || a_log_n != n0 + 1 || a_log_wr[n0] !== 1'b1) begin
            bad++;
            $display("FAIL wr_strobe: got %0d requests wr=%b want 1 write", a_log_n - n0, a_log_wr[n0]);
        end
        total++;
        if (a_log_addr[n0] !== 24'h000ABC || a_log_data[n0] !== 32'h11223344 || a_log_be[n0] !== 4'b0011) begin
            bad++;
            $display("FAIL wr_payload: got %h %h %b want 000abc 11223344 0011", a_log_addr[n0], a_log_data[n0], a_log_be[n0]);
        end
        total++;
        if (a_doc_q !== 32'h0 || a_doc_ready !== 1'b1) begin
            bad++;
            $display("FAIL wr_q_kept: got q=%h ready=%b want 0 1", a_doc_q, a_doc_ready);
        end
    endtask

    task automatic test_rd_wr_both();
        int n0;
        bit ok;
        n0 = a_log_n;
        glu_rd = 1'b1; glu_wr = 1'b1; glu_addr = 24'h000777; glu_data = 32'hCAFEF00D; glu_be = 4'hF;
        tick();
        clear_inputs();
        wait_idle(100, ok);
        total++;
        if (!ok || a_log_n != n0 + 1 || a_log_wr[n0] !== 1'b1 || a_log_data[n0] !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL rdwr_as_write: got n=%0d wr=%b data=%h want 1 1 cafef00d", a_log_n - n0, a_log_wr[n0], a_log_data[n0]);
        end
        total++;
        if (a_glu_q !== 32'h0) begin
            bad++;
            $display("FAIL rdwr_q_kept: got %h want 0", a_glu_q);
        end
    endtask

    task automatic test_ignore_busy();
        int n0;
        bit ok;
        n0 = a_log_n;
        glu_rd = 1'b1; glu_addr = 24'h000111;
        tick();
        glu_addr = 24'h000999;                          // strobe held while busy
        tick();
        glu_wr = 1'b1;
        tick();
        clear_inputs();
        wait_idle(100, ok);
        total++;
        if (!ok || a_log_n != n0 + 1 || a_log_addr[n0] !== 24'h000111) begin
            bad++;
            $display("FAIL busy_ignore: got n=%0d addr=%h want 1 000111", a_log_n - n0, a_log_addr[n0]);
        end
        total++;
        if (a_glu_q !== 32'h5C000111) begin
            bad++;
            $display("FAIL busy_data: got %h want 5c000111", a_glu_q);
        end
    endtask

    task automatic test_reset_midflight();
        int n0;
        bit ok;
        n0 = a_log_n;
        glu_rd = 1'b1; glu_addr = 24'h000222;           // cycle 0
        tick();                                         // cycle 1
        clear_inputs();
        tick(); tick(); tick();                         // cycle 4: WAIT_DONE
        tick();                                         // cycle 5
        reset = 1'b1;
        tick();                                         // cycle 6
        reset = 1'b0;
        total++;
        if ({a_glu_ready, a_doc_ready, a_mem_rd, a_mem_wr} !== 4'b1100 || a_mem_addr !== 24'h0) begin
            bad++;
            $display("FAIL midreset_state: got %b addr=%h want 1100 0", {a_glu_ready, a_doc_ready, a_mem_rd, a_mem_wr}, a_mem_addr);
        end
        for (int i = 0; i < 20 && a_busy; i++) tick();
        tick(); tick(); tick();
        total++;
        if (a_glu_q !== 32'h0 || a_glu_ready !== 1'b1 || a_log_n != n0 + 1) begin
            bad++;
            $display("FAIL midreset_stale: got q=%h ready=%b n=%0d want 0 1 1", a_glu_q, a_glu_ready, a_log_n - n0);
        end
        glu_rd = 1'b1; glu_addr = 24'h000055;
        tick();
        clear_inputs();
        wait_idle(100, ok);
        total++;
        if (!ok || a_glu_q !== 32'h5C000055) begin
            bad++;
            $display("FAIL midreset_next: got q=%h idle=%0d want 5c000055", a_glu_q, ok);
        end
    endtask

`ifdef SOUND_MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int rdy_cyc;
        bit ok;
        do_reset();
        rdy_cyc = -1;
        resp_hang = 1'b1;
        glu_rd = 1'b1; glu_addr = 24'h000333;           // cycle 0
        tick();                                         // cycle 1
        glu_rd = 1'b0;
        doc_rd = 1'b1; doc_addr = 24'h000444;
        tick();                                         // cycle 2
        clear_inputs();
        for (int c = 3; c <= 60 && rdy_cyc < 0; c++) begin
            tick();
            if (a_glu_ready === 1'b1) rdy_cyc = c;
        end
        total++;
        if (rdy_cyc != 19 || a_glu_q !== 32'hFFFFFFFF || a_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_fire: got cyc=%0d q=%h to=%b want 19 ffffffff 1", rdy_cyc, a_glu_q, a_timeout);
        end
        resp_hang = 1'b0;
        wait_idle(200, ok);
        total++;
        if (!ok || a_doc_q !== 32'h5C000444 || a_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_next: got q=%h to=%b idle=%0d want 5c000444 1", a_doc_q, a_timeout, ok);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_glu_read();
        test_doc_priority();
        test_round_robin();
        test_doc_write();
        test_rd_wr_both();
        test_ignore_busy();
        test_reset_midflight();
`ifdef SOUND_MEM_ARB_TIMEOUT_EN
        test_timeout();
`else
        total++;
        if (a_timeout !== 1'b0 || b_timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_tied: got %b %b want 0 0", a_timeout, b_timeout);
        end
`endif
        total++;
        if (a_dbl != 0 || b_dbl != 0) begin
            bad++;
            $display("FAIL strobe_width: got %0d/%0d multi-cycle strobes want 0", a_dbl, b_dbl);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
